// File: rtl/avalon_mm_regfile_slave_if.sv
// Avalon-MM lite bus bundle between a master and the register-file slave.
// The master drives the request fields; the slave drives the response fields.
interface avalon_mm_regfile_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic [1:0]          response;
    logic                waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  readdatavalid,
        input  response,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output readdatavalid,
        output response,
        output waitrequest
    );
endinterface

// File: rtl/avalon_mm_regfile_slave.sv
// Parametrised Avalon-MM lite register-file slave.
// Reads are never stalled and return after a fixed READ_LATENCY through a shift pipeline.
// Writes are held off for WRITE_WAIT waitrequest cycles by a small IDLE/WAIT/ACK FSM.
// Out-of-range reads answer SLAVEERROR with zero data; out-of-range writes are dropped.
// Master misbehaviour (read+write together, read during a write stall, write withdrawn
// mid-stall) sets a sticky proto_err flag that only reset clears.
module avalon_mm_regfile_slave #(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       NUM_REGS     = 8,
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       READ_LATENCY = 2,
    parameter int unsigned       WRITE_WAIT   = 1,
    parameter logic [DATA_W-1:0] RESET_VAL    = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    avalon_mm_regfile_slave_if.slave     bus,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         proto_err
);
    localparam int unsigned NB = DATA_W / 8;

    // Write FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register storage
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Holds waitrequest high until the first edge after reset release
    logic              r_init;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic              r_proto_err;

    // Read pipeline: index 0 captures at acceptance, index READ_LATENCY drives the bus
    logic [READ_LATENCY:0] r_pipe_vld;
    logic [DATA_W-1:0]     r_pipe_data [READ_LATENCY+1];
    logic [1:0]            r_pipe_resp [READ_LATENCY+1];

    logic              w_addr_hit;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_violation;
    logic              w_waitreq;

    // Address decode and read mux; a miss leaves w_rd_data at zero
    always_comb begin
        w_addr_hit = 1'b0;
        w_rd_data  = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (bus.address == ADDR_W'(i)) begin
                w_addr_hit = 1'b1;
                w_rd_data  = r_regs[i];
            end
        end
    end

    // Write FSM next state, acceptance strobes, waitrequest and violation detection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_accept = 1'b0;
        w_rd_accept = 1'b0;
        w_violation = 1'b0;
        w_waitreq   = r_init;
        if (!r_init) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.write) begin
                        // A read alongside a write is dropped; the write proceeds
                        if (bus.read) begin
                            w_violation = 1'b1;
                        end
                        if (WRITE_WAIT == 0) begin
                            w_wr_accept = 1'b1;
                        end else begin
                            // This cycle is the first stall cycle
                            w_waitreq   = 1'b1;
                            w_state_nxt = (WRITE_WAIT > 1) ? S_WAIT : S_ACK;
                            w_cnt_nxt   = (WRITE_WAIT > 1) ? 2'(WRITE_WAIT - 2) : 2'd0;
                        end
                    end else if (bus.read) begin
                        w_rd_accept = 1'b1;
                    end
                end
                S_WAIT: begin
                    w_waitreq = 1'b1;
                    if (bus.read) begin
                        w_violation = 1'b1;
                    end
                    if (!bus.write) begin
                        // Master withdrew the write mid-stall: discard it
                        w_violation = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == 2'd0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                S_ACK: begin
                    if (bus.read) begin
                        w_violation = 1'b1;
                    end
                    if (bus.write) begin
                        w_wr_accept = 1'b1;
                    end else begin
                        w_violation = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Reset-release stall flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init <= 1'b1;
        end else begin
            r_init <= 1'b0;
        end
    end

    // Write FSM state and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_proto_err <= 1'b0;
        end else if (w_violation) begin
            r_proto_err <= 1'b1;
        end
    end

    // Register file update with per-byte lane enables; out-of-range writes match no entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_wr_accept) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (bus.address == ADDR_W'(i)) begin
                    for (int b = 0; b < int'(NB); b++) begin
                        if (bus.byteenable[b]) begin
                            r_regs[i][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read response pipeline; data and response are captured at acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int k = 0; k <= int'(READ_LATENCY); k++) begin
                r_pipe_data[k] <= '0;
                r_pipe_resp[k] <= RESP_OKAY;
            end
        end else begin
            r_pipe_vld[0]  <= w_rd_accept;
            r_pipe_data[0] <= w_rd_accept ? w_rd_data : '0;
            r_pipe_resp[0] <= (w_rd_accept && !w_addr_hit) ? RESP_SLVERR : RESP_OKAY;
            for (int k = 1; k <= int'(READ_LATENCY); k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_data[k] <= r_pipe_data[k-1];
                r_pipe_resp[k] <= r_pipe_resp[k-1];
            end
        end
    end

    assign bus.readdata      = r_pipe_data[READ_LATENCY];
    assign bus.readdatavalid = r_pipe_vld[READ_LATENCY];
    assign bus.response      = r_pipe_resp[READ_LATENCY];
    assign bus.waitrequest   = w_waitreq;
    assign proto_err         = r_proto_err;

    // Flat export of register contents, straight from the storage flops
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
        assign regs_out[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

endmodule

// File: doc/avalon_mm_regfile_slave.md
Name: avalon_mm_regfile_slave

Overview:
- Parametrised Avalon-MM lite slave register file; next generation of the single-mode example slave.
- Adds configurable data width, register count and pipelined read latency (readdatavalid), per-byte write enables, write wait-states, error response for out-of-range addresses, and protocol-violation detection.
- Sits behind the avalon_mm_lite slave modport; register contents are exported flat to downstream logic.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8, range 8..64.
- NUM_REGS, 8, number of registers; range 1..2**ADDR_W.
- ADDR_W, 4, word address width.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; range 1..4.
- WRITE_WAIT, 1, waitrequest cycles inserted before each write is accepted; range 0..3.
- RESET_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  write byte lanes.
- readdata  out  DATA_W  read data; valid only with readdatavalid.
- readdatavalid  out  1  read data strobe.
- response  out  2  00 OKAY, 10 SLAVEERROR; qualified by readdatavalid.
- waitrequest  out  1  slave stall.
- regs_out  out  NUM_REGS*DATA_W  register contents; reg i at bits [i*DATA_W +: DATA_W].
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock domain, clk; reset is asynchronous and active-low on reset_n. Assertion clears all state immediately; release is synchronous to clk.
- Reset values: registers = RESET_VAL; readdata = 0; readdatavalid = 0; response = 00; proto_err = 0; waitrequest = 1 while reset_n low and for the first clk edge after release, then 0.
- Acceptance: a request is accepted on a rising edge where it is asserted and waitrequest is 0.
- Reads:
  - Never stalled (waitrequest stays 0 for reads).
  - A read accepted at edge N drives readdatavalid high for exactly one cycle after edge N+READ_LATENCY.
  - Data is sampled at acceptance. A write accepted at edge N is visible to a read accepted at N+1 or later.
  - Back-to-back reads are fully pipelined, one per cycle. Maximum outstanding reads = READ_LATENCY, carried in a shift pipeline of {valid, data, resp}.
- Writes:
  - FSM states: IDLE, WAIT, ACK.
  - IDLE + write: if WRITE_WAIT=0, accept at this edge and stay in IDLE. Otherwise go to WAIT with waitrequest held high and load a wait counter.
  - WAIT: decrement the counter each cycle. After WRITE_WAIT cycles of waitrequest high, go to ACK with waitrequest low; the write is accepted at that edge and the FSM returns to IDLE.
  - If write drops while in WAIT/ACK (master violation): proto_err is set, the write is discarded, and the FSM returns to IDLE.
  - Byte lane k updates only when byteenable[k]=1. All-zero byteenable is accepted with no register change.
- Address range: address >= NUM_REGS on a write is accepted and ignored. On a read it returns readdata = 0 with response = 10.
- Simultaneous read and write in the same cycle:
  - The write is processed and the read is dropped (no readdatavalid for it); proto_err is set.
  - Likewise, a read asserted while the FSM is in WAIT/ACK is dropped and proto_err is set.
- proto_err stays set until reset.
- Reset mid-operation: pending readdatavalid pulses are flushed, and a write in WAIT is discarded.
- regs_out updates on the edge after write acceptance; it is registered, with no combinational path from inputs.

Test Plan:
- Reset/defaults: hold reset_n=0 for 10 cycles, then release. Required: waitrequest=1 until the first edge after release, regs_out all 0, proto_err=0, readdatavalid=0 throughout.
- Write/read-back: DATA_W=32, WRITE_WAIT=1. Write 0xA5A5_1234 to address 3 with byteenable=1111. Required: exactly 1 waitrequest cycle, then accept. A read of address 3, READ_LATENCY=2, gives readdatavalid 2 cycles after acceptance, readdata=0xA5A5_1234, response=00.
- Byte enables: address 3 holds 0xA5A5_1234. Write 0xFFFF_FFFF with byteenable=0101. Required: readback 0xA5FF_12FF.
- Pipelined reads: issue 4 consecutive reads to addresses 0..3 with READ_LATENCY=3. Required: 4 consecutive readdatavalid cycles starting 3 cycles after the first read, data in issue order, waitrequest never asserted.
- Error response: with NUM_REGS=8, read address 9 and write address 12. Required: read returns 0 with response=10. The write is accepted and regs_out is unchanged.
- Violations and reset: assert read and write together; then, on a separate run, pulse reset_n low during a write in WAIT. Required: in the first case the write is applied, no readdatavalid is produced, and proto_err=1 sticky. In the second case the register is unchanged, no readdatavalid pulses appear after reset, and proto_err clears.
